pmp_csr_regs: RTL and testbench

PMP_CSR_REGS -- requirements
Module: pmp_csr_regs

---
 rtl/pmp_csr_regs_pkg.sv | 14 +
 rtl/riscv_pkg.sv | 35 +++
 rtl/pmp_cfg_legalize.sv | 20 ++
 rtl/pmp_csr_regs.sv | 136 +++++++++++++
 tb/tb_pmp_csr_regs.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/pmp_csr_regs_pkg.sv
// Local helpers for the PMP CSR register file.
// Address decode shared by the top and its sub-blocks.
package pmp_csr_regs_pkg;
  import riscv::*;

  localparam int unsigned NUM_PMP = 16;

  function automatic logic is_pmpaddr(
    input logic [11:0] a
  );
    return (a & 12'hFF0) == CSR_PMPADDR0;
  endfunction

endpackage

// File: rtl/riscv_pkg.sv
// Shared RISC-V privilege, PMP configuration types
// and CSR address constants.
package riscv;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    TOR   = 2'b01,
    NA4   = 2'b10,
    NAPOT = 2'b11
  } pmp_addr_mode_t;

  typedef struct packed {
    logic x;
    logic w;
    logic r;
  } pmp_access_t;

  typedef struct packed {
    logic           locked;
    logic [1:0]     reserved;
    pmp_addr_mode_t addr_mode;
    pmp_access_t    access_type;
  } pmpcfg_t;

  localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
  localparam logic [11:0] CSR_PMPCFG2  = 12'h3A2;
  localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

endpackage

// File: rtl/pmp_cfg_legalize.sv
// WARL legalization of one written pmpcfg byte.
// Reserved bits forced 0; R=0,W=1 collapses to R=0,W=0.
module pmp_cfg_legalize
  import riscv::*;
(
  input  pmpcfg_t cfg_i,
  output pmpcfg_t cfg_o
);

  logic unused_reserved;
  assign unused_reserved = ^cfg_i.reserved;

  always_comb begin
    cfg_o          = cfg_i;
    cfg_o.reserved = 2'b00;
    if (!cfg_i.access_type.r && cfg_i.access_type.w)
      cfg_o.access_type.w = 1'b0;
  end

endmodule

// File: rtl/pmp_csr_regs.sv
// PMP configuration and address CSR register file
// with a one-cycle response and pre-write read data.
module pmp_csr_regs
  import riscv::*;
  import pmp_csr_regs_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned PMP_LEN    = 54,
  parameter int unsigned NR_ENTRIES = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_i,
  input  logic                           we_i,
  input  logic [11:0]                    addr_i,
  input  logic [XLEN-1:0]                wdata_i,
  input  riscv::priv_lvl_t               priv_lvl_i,
  output logic                           rvalid_o,
  output logic [XLEN-1:0]                rdata_o,
  output logic                           err_o,
  output logic [15:0][PMP_LEN-1:0]       conf_addr_o,
  output riscv::pmpcfg_t [15:0]          conf_o
);

  logic            is_cfg0;
  logic            is_cfg2;
  logic            is_addr;
  logic            legal;
  logic            wr_en;
  logic [3:0]      idx;
  logic [XLEN-1:0] rd_val;

  logic            rvalid_d, rvalid_q;
  logic            err_d, err_q;
  logic [XLEN-1:0] rdata_d, rdata_q;

  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

  assign idx = addr_i[3:0];

  always_comb begin
    is_cfg0 = addr_i == CSR_PMPCFG0;
    is_cfg2 = addr_i == CSR_PMPCFG2;
    is_addr = is_pmpaddr(addr_i);
    legal   = (is_cfg0 | is_cfg2 | is_addr)
            && priv_lvl_i == PRIV_LVL_M;
    wr_en   = req_i && we_i && legal;
  end

  // Unimplemented entries are tied to zero, so
  // reading through the outputs covers them.
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      is_cfg0: rd_val = XLEN'(conf_o[7:0]);
      is_cfg2: rd_val = XLEN'(conf_o[15:8]);
      is_addr: rd_val = XLEN'(conf_addr_o[idx]);
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    rvalid_d = req_i;
    err_d    = req_i && !legal;
    rdata_d  = (req_i && legal) ? rd_val : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

  for (genvar i = 0; i < 16; i++) begin : g_ent
    if (i < NR_ENTRIES) begin : g_impl
      pmpcfg_t             cfg_d, cfg_q;
      pmpcfg_t             cfg_new;
      logic [PMP_LEN-1:0]  addr_d, addr_q;
      logic                tor_lock;
      logic                cfg_sel;

      pmp_cfg_legalize u_legalize (
        .cfg_i (pmpcfg_t'(wdata_i[8*(i%8)+:8])),
        .cfg_o (cfg_new)
      );

      if (i < 15) begin : g_nxt
        assign tor_lock = conf_o[i+1].locked
          && conf_o[i+1].addr_mode == TOR;
      end else begin : g_last
        assign tor_lock = 1'b0;
      end

      assign cfg_sel = (i < 8) ? is_cfg0 : is_cfg2;

      // Lock checks use the stored (pre-write) state.
      always_comb begin
        cfg_d  = cfg_q;
        addr_d = addr_q;
        if (wr_en && cfg_sel && !cfg_q.locked)
          cfg_d = cfg_new;
        if (wr_en && is_addr && idx == 4'(i)
            && !cfg_q.locked && !tor_lock)
          addr_d = wdata_i[PMP_LEN-1:0];
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cfg_q  <= '0;
          addr_q <= '0;
        end else begin
          cfg_q  <= cfg_d;
          addr_q <= addr_d;
        end
      end

      assign conf_o[i]      = cfg_q;
      assign conf_addr_o[i] = addr_q;
    end else begin : g_none
      assign conf_o[i]      = '0;
      assign conf_addr_o[i] = '0;
    end
  end

endmodule

// File: tb/tb_pmp_csr_regs.sv
// Directed table-driven bench for pmp_csr_regs.
// Vectors run back-to-back; state carries across rows.
module tb_pmp_csr_regs;
  import riscv::*;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic                  req_i;
  logic                  we_i;
  logic [11:0]           addr_i;
  logic [63:0]           wdata_i;
  priv_lvl_t             priv_lvl_i;
  logic                  rvalid_o;
  logic [63:0]           rdata_o;
  logic                  err_o;
  logic [15:0][53:0]     conf_addr_o;
  pmpcfg_t [15:0]        conf_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pmp_csr_regs dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .priv_lvl_i  (priv_lvl_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .conf_addr_o (conf_addr_o),
    .conf_o      (conf_o)
  );

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [63:0] wdata;
    priv_lvl_t   priv;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic        we,
    input logic [11:0] addr,
    input logic [63:0] wdata,
    input priv_lvl_t   priv,
    input logic [63:0] exp_rdata,
    input logic        exp_err
  );
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata;
    v.priv = priv; v.exp_rdata = exp_rdata;
    v.exp_err = exp_err;
    return v;
  endfunction

  task automatic run(input vec_t v, input string tag);
    @(negedge clk);
    req_i      = 1'b1;
    we_i       = v.we;
    addr_i     = v.addr;
    wdata_i    = v.wdata;
    priv_lvl_i = v.priv;
    @(posedge clk);
    #1;
    chk({tag, " rvalid"}, 64'(rvalid_o), 64'd1);
    chk({tag, " rdata"}, rdata_o, v.exp_rdata);
    chk({tag, " err"}, 64'(err_o), 64'(v.exp_err));
    req_i = 1'b0;
    we_i  = 1'b0;
  endtask

  localparam logic W = 1'b1;
  localparam logic R = 1'b0;

  initial begin
    rst_i      = 1'b1;
    req_i      = 1'b0;
    we_i       = 1'b0;
    addr_i     = '0;
    wdata_i    = '0;
    priv_lvl_i = PRIV_LVL_M;

    vecs.push_back(mk(W, 12'h3A0, 64'h0F, PRIV_LVL_M, 64'h0, 0));
    vecs.push_back(mk(R, 12'h3A0, 64'h0, PRIV_LVL_M, 64'h0F, 0));
    vecs.push_back(mk(W, 12'h3A0, 64'h62, PRIV_LVL_M, 64'h0F, 0));
    vecs.push_back(mk(R, 12'h3A0, 64'h0, PRIV_LVL_M, 64'h00, 0));
    vecs.push_back(mk(W, 12'h3B0, 64'h1234, PRIV_LVL_M, 64'h0, 0));
    vecs.push_back(mk(W, 12'h3B0, 64'hFFFF, PRIV_LVL_S, 64'h0, 1));
    vecs.push_back(mk(R, 12'h3A1, 64'h0, PRIV_LVL_M, 64'h0, 1));
    vecs.push_back(mk(W, 12'h3A3, 64'hFF, PRIV_LVL_M, 64'h0, 1));
    vecs.push_back(mk(R, 12'h300, 64'h0, PRIV_LVL_M, 64'h0, 1));
    vecs.push_back(mk(R, 12'h3A0, 64'h0, PRIV_LVL_U, 64'h0, 1));
    vecs.push_back(mk(R, 12'h3B0, 64'h0, PRIV_LVL_M, 64'h1234, 0));
    vecs.push_back(mk(W, 12'h3A0, 64'h9F, PRIV_LVL_M, 64'h0, 0));
    vecs.push_back(mk(W, 12'h3A0, 64'h00, PRIV_LVL_M, 64'h9F, 0));
    vecs.push_back(mk(W, 12'h3B0, 64'h5678, PRIV_LVL_M, 64'h1234, 0));
    vecs.push_back(mk(R, 12'h3A0, 64'h0, PRIV_LVL_M, 64'h9F, 0));
    vecs.push_back(mk(R, 12'h3B0, 64'h0, PRIV_LVL_M, 64'h1234, 0));
    vecs.push_back(mk(W, 12'h3A0, 64'h889F, PRIV_LVL_M, 64'h9F, 0));
    vecs.push_back(mk(R, 12'h3A0, 64'h0, PRIV_LVL_M, 64'h889F, 0));
    vecs.push_back(mk(W, 12'h3B1, 64'h55, PRIV_LVL_M, 64'h0, 0));
    vecs.push_back(mk(R, 12'h3B1, 64'h0, PRIV_LVL_M, 64'h0, 0));
    vecs.push_back(mk(W, 12'h3B0, 64'h55, PRIV_LVL_M, 64'h1234, 0));
    vecs.push_back(mk(R, 12'h3B0, 64'h0, PRIV_LVL_M, 64'h1234, 0));
    vecs.push_back(mk(W, 12'h3B2, 64'hABC, PRIV_LVL_M, 64'h0, 0));
    vecs.push_back(mk(R, 12'h3B2, 64'h0, PRIV_LVL_M, 64'hABC, 0));
    vecs.push_back(mk(W, 12'h3A0, 64'h000F_0000, PRIV_LVL_M,
                      64'h889F, 0));
    vecs.push_back(mk(R, 12'h3A0, 64'h0, PRIV_LVL_M,
                      64'h0F_889F, 0));
    vecs.push_back(mk(W, 12'h3A2, 64'h1F00_0000_0000_0007,
                      PRIV_LVL_M, 64'h0, 0));
    vecs.push_back(mk(R, 12'h3A2, 64'h0, PRIV_LVL_M,
                      64'h1F00_0000_0000_0007, 0));
    vecs.push_back(mk(W, 12'h3BF, 64'hFFFF_FFFF_FFFF_FFFF,
                      PRIV_LVL_M, 64'h0, 0));
    vecs.push_back(mk(R, 12'h3BF, 64'h0, PRIV_LVL_M,
                      64'h003F_FFFF_FFFF_FFFF, 0));
    vecs.push_back(mk(W, 12'h3B3, 64'h777, PRIV_LVL_M, 64'h0, 0));
    vecs.push_back(mk(R, 12'h3B3, 64'h0, PRIV_LVL_M, 64'h777, 0));
    vecs.push_back(mk(W, 12'h3B4, 64'hFFFF, PRIV_LVL_S, 64'h0, 1));
    vecs.push_back(mk(R, 12'h3B4, 64'h0, PRIV_LVL_M, 64'h0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset rvalid", 64'(rvalid_o), 64'd0);
    chk("reset err", 64'(err_o), 64'd0);
    chk("reset rdata", rdata_o, 64'd0);
    chk("reset conf", 64'(conf_o == '0), 64'd1);
    chk("reset conf_addr", 64'(conf_addr_o == '0), 64'd1);
    @(negedge clk);
    rst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run(vecs[i], $sformatf("vec%0d", i));
      if (i == 1)
        chk("conf0 tor rwx", 64'(conf_o[0]), 64'h0F);
    end

    @(posedge clk);
    #1;
    chk("rvalid single pulse", 64'(rvalid_o), 64'd0);
    chk("conf0", 64'(conf_o[0]), 64'h9F);
    chk("conf1", 64'(conf_o[1]), 64'h88);
    chk("conf2", 64'(conf_o[2]), 64'h0F);
    chk("conf8", 64'(conf_o[8]), 64'h07);
    chk("conf15", 64'(conf_o[15]), 64'h1F);
    chk("conf_addr0", 64'(conf_addr_o[0]), 64'h1234);
    chk("conf_addr1", 64'(conf_addr_o[1]), 64'h0);
    chk("conf_addr2", 64'(conf_addr_o[2]), 64'hABC);
    chk("conf_addr3", 64'(conf_addr_o[3]), 64'h777);
    chk("conf_addr4", 64'(conf_addr_o[4]), 64'h0);
    chk("conf_addr15", 64'(conf_addr_o[15]),
        64'h003F_FFFF_FFFF_FFFF);

    // Reset with a request in the same cycle.
    @(negedge clk);
    rst_i   = 1'b1;
    req_i   = 1'b1;
    we_i    = 1'b1;
    addr_i  = 12'h3B3;
    wdata_i = 64'h1;
    priv_lvl_i = PRIV_LVL_M;
    @(posedge clk);
    #1;
    chk("mid rst rvalid", 64'(rvalid_o), 64'd0);
    chk("mid rst rdata", rdata_o, 64'd0);
    chk("mid rst conf", 64'(conf_o == '0), 64'd1);
    chk("mid rst conf_addr", 64'(conf_addr_o == '0), 64'd1);
    req_i = 1'b0;
    we_i  = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    chk("post rst no rvalid", 64'(rvalid_o), 64'd0);

    run(mk(W, 12'h3A0, 64'h0F, PRIV_LVL_M, 64'h0, 0), "unlock w");
    run(mk(R, 12'h3A0, 64'h0, PRIV_LVL_M, 64'h0F, 0), "unlock r");
    run(mk(W, 12'h3B0, 64'h42, PRIV_LVL_M, 64'h0, 0), "a0 w");
    run(mk(R, 12'h3B0, 64'h0, PRIV_LVL_M, 64'h42, 0), "a0 r");
    run(mk(R, 12'h3B3, 64'h0, PRIV_LVL_M, 64'h0, 0), "a3 r");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
